bscan_cmd_bridge: RTL
=====================

Name: bscan_cmd_bridge

Overview:
- Downstream consumer of the Bscan block's fromBscan word stream; upstream producer of its toBscan reply stream.
- Decodes 32-bit JTAG command words into register-bus read/write requests with optional incrementing bursts.
- Returns read data and error words to the host through toBscan.
- Sits between the Bscan block and the on-chip debug register bus.

Parameters:
- WIDTH, 32, JTAG word width; must match the BscanLocal width.
- ADDR_WIDTH, 16, register-bus address width; must be ≤ 16.

Ports:
- CLK  input  1  system clock, the same clock as the Bscan block's fromBscan/toBscan side.
- RST  input  1  reset, synchronous and active-high.
- fromBscan_enq__ENA  input  1  command/data word valid from Bscan.
- fromBscan_enq_v  input  WIDTH  command/data word.
- fromBscan_enq__RDY  output  1  bridge can accept a word.
- toBscan_enq__ENA  output  1  reply word valid to Bscan.
- toBscan_enq_v  output  WIDTH  reply word.
- toBscan_enq__RDY  input  1  Bscan can take a reply; asserted only in its capture window.
- req__ENA  output  1  bus request valid.
- req_write  output  1  1 = write, 0 = read.
- req_addr  output  ADDR_WIDTH  bus address.
- req_data  output  WIDTH  write data; 0 when req_write = 0.
- req__RDY  input  1  bus accepts the request this cycle.
- rsp__ENA  input  1  read response valid.
- rsp_data  input  WIDTH  read data.
- rsp__RDY  output  1  bridge accepts a response.
- busy  output  1  state != IDLE.
- errCount  output  8  saturating count of illegal commands.

Behaviour:
- Command word format:
  - [31:30] opcode: 00 NOP, 01 WRITE, 10 READ, 11 illegal.
  - [23:16] burst length minus 1; burst is 1..256 words.
  - [ADDR_WIDTH-1:0] start address.
  - Bits [29:24] are ignored.
- Handshake: a transfer occurs in a cycle where ENA and RDY are both 1. Every ENA/RDY output is a pure function of the state register. ENA, once raised, holds with stable data until the transfer.
- States: IDLE, WDATA, WREQ, RREQ, RWAIT, RSEND, ERRSEND.
- IDLE: fromBscan_enq__RDY = 1. On a transfer:
  - NOP: stay in IDLE.
  - WRITE: latch addr and cnt = burst field; go to WDATA.
  - READ: latch addr and cnt; go to RREQ.
  - Illegal: latch word; errCount increments and saturates at 255; go to ERRSEND.
- WDATA: fromBscan_enq__RDY = 1. On a transfer, latch the word into the data register; go to WREQ.
- WREQ: req__ENA = 1, req_write = 1. On req__RDY:
  - cnt == 0: go to IDLE.
  - otherwise: cnt--, addr++; go to WDATA.
- RREQ: req__ENA = 1, req_write = 0. On req__RDY, go to RWAIT.
- RWAIT: rsp__RDY = 1. On rsp__ENA, latch rsp_data; go to RSEND.
- RSEND: toBscan_enq__ENA = 1, toBscan_enq_v = latched data. On toBscan_enq__RDY:
  - cnt == 0: go to IDLE.
  - otherwise: cnt--, addr++; go to RREQ.
- ERRSEND: toBscan_enq__ENA = 1, toBscan_enq_v = {8'hEE, latched word[23:0]}. On RDY, go to IDLE.
- fromBscan_enq__RDY = 0 in every state other than IDLE and WDATA. Words offered in those states are not accepted and are not buffered; preventing that is the host's responsibility.
- rsp__ENA outside RWAIT is ignored.
- Latency:
  - One write word to req__ENA: 1 cycle.
  - req/rsp to toBscan_enq__ENA: 1 cycle after rsp__ENA.
  - RSEND/ERRSEND hold indefinitely until the capture window; there is no timeout.
- addr increments modulo 2^ADDR_WIDTH: 0xFFFF wraps to 0x0000.
- cnt is 8 bits. Burst field 0xFF gives 256 transfers.
- Reset: a clock edge with RST = 1 forces the following, from any state including mid-burst:
  - state = IDLE
  - addr = 0, cnt = 0, data = 0
  - errCount = 0
- While RST = 1, all ENA/RDY outputs are 0.
- Reset values: busy = 0; errCount = 0; toBscan_enq_v = 0; req_addr = 0; req_data = 0.
- A partial burst in flight at reset is abandoned without a reply.

Test Plan:
- Single write: push 0x4000_0010, then 0xCAFE_F00D; req__RDY = 1 → exactly one req with write = 1, addr = 0x0010, data = 0xCAFEF00D; busy returns to 0; no toBscan traffic.
- Read burst of 3: push 0x8002_0020; bus returns 0x11, 0x22, 0x33 one cycle after each req; toBscan_enq__RDY pulses once every 50 cycles → req addrs 0x20, 0x21, 0x22 in order; toBscan words 0x11, 0x22, 0x33, each held stable until its RDY pulse.
- Wrap and backpressure: write burst 2 at 0xFFFF with req__RDY low for 5 cycles per request → addrs 0xFFFF then 0x0000; req fields stable while stalled; fromBscan_enq__RDY = 0 during WREQ.
- Illegal opcode: push 0xC012_3456 → toBscan word 0xEE123456; errCount = 1. Then 300 illegal words → errCount = 255, saturated.
- Reset mid-burst: READ burst 4, assert RST during the second RSEND → next cycle all ENA = 0, busy = 0, errCount = 0. A following NOP followed by a single read behaves normally.
- NOP and stray response: push 0x0000_0000 and pulse rsp__ENA while in IDLE → no req, no toBscan word, busy stays 0.

Source files
------------

// File: rtl/bscan_cmd_bridge_if.sv
// Signal bundle between the Bscan word streams, the bridge and the debug register bus.
// The master view belongs to the bridge; the slave view is for the Bscan block and the bus.
interface bscan_cmd_bridge_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  fromBscan_enq__ENA;
  logic [WIDTH-1:0]      fromBscan_enq_v;
  logic                  fromBscan_enq__RDY;

  logic                  toBscan_enq__ENA;
  logic [WIDTH-1:0]      toBscan_enq_v;
  logic                  toBscan_enq__RDY;

  logic                  req__ENA;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WIDTH-1:0]      req_data;
  logic                  req__RDY;

  logic                  rsp__ENA;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp__RDY;

  modport master (
    input  fromBscan_enq__ENA, fromBscan_enq_v,
    output fromBscan_enq__RDY,
    output toBscan_enq__ENA, toBscan_enq_v,
    input  toBscan_enq__RDY,
    output req__ENA, req_write, req_addr, req_data,
    input  req__RDY,
    input  rsp__ENA, rsp_data,
    output rsp__RDY
  );

  modport slave (
    output fromBscan_enq__ENA, fromBscan_enq_v,
    input  fromBscan_enq__RDY,
    input  toBscan_enq__ENA, toBscan_enq_v,
    output toBscan_enq__RDY,
    input  req__ENA, req_write, req_addr, req_data,
    output req__RDY,
    output rsp__ENA, rsp_data,
    input  rsp__RDY
  );
endinterface

// File: rtl/bscan_cmd_bridge.sv
// Decodes JTAG command words from Bscan into register-bus reads/writes with incrementing
// bursts, and returns read data or error words to the host through the toBscan stream.
module bscan_cmd_bridge #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  bscan_cmd_bridge_if.master       bus,
  output logic                     busy,
  output logic [7:0]               errCount
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_WREQ,
    ST_RREQ,
    ST_RWAIT,
    ST_RSEND,
    ST_ERRSEND
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [7:0] ERR_TAG  = 8'hEE;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [7:0]            r_cnt;
  logic [7:0]            w_cnt_next;
  logic [WIDTH-1:0]      r_data;
  logic [WIDTH-1:0]      w_data_next;
  logic [7:0]            r_err_count;
  logic [7:0]            w_err_count_next;

  logic                  w_from_rdy;
  logic                  w_to_ena;
  logic                  w_req_ena;
  logic                  w_rsp_rdy;
  logic                  w_from_fire;
  logic                  w_to_fire;
  logic                  w_req_fire;
  logic                  w_rsp_fire;
  logic [1:0]            w_opcode;
  logic [7:0]            w_burst;
  logic [WIDTH-1:0]      w_err_word;
  logic                  w_unused_bits;

  // Handshake flags depend only on the state; reset masks them so nothing moves while RST is high.
  assign w_from_rdy = !RST && ((r_state == ST_IDLE) || (r_state == ST_WDATA));
  assign w_to_ena   = !RST && ((r_state == ST_RSEND) || (r_state == ST_ERRSEND));
  assign w_req_ena  = !RST && ((r_state == ST_WREQ) || (r_state == ST_RREQ));
  assign w_rsp_rdy  = !RST && (r_state == ST_RWAIT);

  assign w_from_fire = w_from_rdy && bus.fromBscan_enq__ENA;
  assign w_to_fire   = w_to_ena && bus.toBscan_enq__RDY;
  assign w_req_fire  = w_req_ena && bus.req__RDY;
  assign w_rsp_fire  = w_rsp_rdy && bus.rsp__ENA;

  assign w_opcode      = bus.fromBscan_enq_v[31:30];
  assign w_burst       = bus.fromBscan_enq_v[23:16];
  assign w_unused_bits = ^bus.fromBscan_enq_v[29:24];

  always_comb begin
    w_err_word        = r_data;
    w_err_word[31:24] = ERR_TAG;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_data      <= '0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_addr      <= w_addr_next;
      r_cnt       <= w_cnt_next;
      r_data      <= w_data_next;
      r_err_count <= w_err_count_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_addr_next      = r_addr;
    w_cnt_next       = r_cnt;
    w_data_next      = r_data;
    w_err_count_next = r_err_count;
    unique case (r_state)
      ST_IDLE: begin
        if (w_from_fire) begin
          unique case (w_opcode)
            OP_NOP: w_state_next = ST_IDLE;
            OP_WRITE: begin
              w_addr_next  = bus.fromBscan_enq_v[ADDR_WIDTH-1:0];
              w_cnt_next   = w_burst;
              w_state_next = ST_WDATA;
            end
            OP_READ: begin
              w_addr_next  = bus.fromBscan_enq_v[ADDR_WIDTH-1:0];
              w_cnt_next   = w_burst;
              w_state_next = ST_RREQ;
            end
            default: begin
              // The offending word is kept in the data register for the error reply.
              w_data_next  = bus.fromBscan_enq_v;
              if (r_err_count != 8'hFF) begin
                w_err_count_next = r_err_count + 8'd1;
              end
              w_state_next = ST_ERRSEND;
            end
          endcase
        end
      end
      ST_WDATA: begin
        if (w_from_fire) begin
          w_data_next  = bus.fromBscan_enq_v;
          w_state_next = ST_WREQ;
        end
      end
      ST_WREQ: begin
        if (w_req_fire) begin
          if (r_cnt == 8'd0) begin
            w_state_next = ST_IDLE;
          end else begin
            w_cnt_next   = r_cnt - 8'd1;
            w_addr_next  = r_addr + ADDR_ONE;
            w_state_next = ST_WDATA;
          end
        end
      end
      ST_RREQ: begin
        if (w_req_fire) begin
          w_state_next = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        if (w_rsp_fire) begin
          w_data_next  = bus.rsp_data;
          w_state_next = ST_RSEND;
        end
      end
      ST_RSEND: begin
        // The reply waits here for the Bscan capture window, however long that takes.
        if (w_to_fire) begin
          if (r_cnt == 8'd0) begin
            w_state_next = ST_IDLE;
          end else begin
            w_cnt_next   = r_cnt - 8'd1;
            w_addr_next  = r_addr + ADDR_ONE;
            w_state_next = ST_RREQ;
          end
        end
      end
      ST_ERRSEND: begin
        if (w_to_fire) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.toBscan_enq_v = '0;
    if (r_state == ST_RSEND) begin
      bus.toBscan_enq_v = r_data;
    end else if (r_state == ST_ERRSEND) begin
      bus.toBscan_enq_v = w_err_word;
    end
  end

  assign bus.fromBscan_enq__RDY = w_from_rdy;
  assign bus.toBscan_enq__ENA   = w_to_ena;
  assign bus.req__ENA           = w_req_ena;
  assign bus.req_write          = (r_state == ST_WREQ);
  assign bus.req_addr           = r_addr;
  assign bus.req_data           = (r_state == ST_WREQ) ? r_data : '0;
  assign bus.rsp__RDY           = w_rsp_rdy;

  assign busy     = (r_state != ST_IDLE);
  assign errCount = r_err_count;

endmodule
